// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM stage with multi-cycle data memory and MEM/WB pipeline register
// Optional misaligned-access trap enabled by defining MEM_ALIGN_CHECK_EN.
module mem_wb_stage #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_m,
    input  logic              reg_write_m,
    input  logic              mem_write_m,
    input  logic              mem_read_m,
    input  logic              result_src_m,
    input  logic [4:0]        rd_m,
    input  logic [1:0]        size_m,
    input  logic              unsigned_m,
    input  logic [DATA_W-1:0] alu_result_m,
    input  logic [DATA_W-1:0] write_data_m,
    input  logic              flush_m,
    output logic              stall_m,
    output logic              valid_w,
    output logic              reg_write_w,
    output logic              result_src_w,
    output logic [4:0]        rd_w,
    output logic [DATA_W-1:0] alu_result_w,
    output logic [DATA_W-1:0] read_data_w,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              misalign_w,
`endif
    output logic [DATA_W-1:0] result_w
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     idx;
    logic [LB-1:0]     lane_raw;
    logic [LB-1:0]     lane;
    logic              is_byte;
    logic              is_half;
    logic              is_word;
    logic              mem_op;
    logic              multi;
    logic              complete;
    logic              mem_we;
    logic              bad_addr;
    logic [NB-1:0]     be;
    logic [DATA_W-1:0] wdata_sh;
    logic [DATA_W-1:0] rword_sh;
    logic [DATA_W-1:0] load_val;
    logic              unused_addr;

    assign idx         = alu_result_m[AW+LB-1:LB];
    assign lane_raw    = alu_result_m[LB-1:0];
    assign unused_addr = &{1'b0, alu_result_m[DATA_W-1:AW+LB]};
    assign is_byte     = (size_m == 2'b00);
    assign is_half     = (size_m == 2'b01);
    assign is_word     = size_m[1];

    assign mem_op = valid_m & (mem_read_m | mem_write_m);

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_addr = mem_op & ((is_half & lane_raw[0]) | (is_word & (|lane_raw)));
`else
    assign bad_addr = 1'b0;
`endif

    // Without the trap, half/word accesses silently drop the offending low address bits.
    always_comb begin
        lane = lane_raw;
        if (is_half) begin
            lane[0] = 1'b0;
        end else if (is_word) begin
            lane = '0;
        end
    end

    always_comb begin
        if (is_byte) begin
            be = NB'(1) << lane;
        end else if (is_half) begin
            be = NB'(3) << lane;
        end else begin
            be = '1;
        end
    end

    assign wdata_sh = write_data_m << {lane, 3'b000};
    assign rword_sh = mem[idx] >> {lane, 3'b000};

    always_comb begin
        if (is_byte) begin
            load_val = {{(DATA_W-8){rword_sh[7] & ~unsigned_m}}, rword_sh[7:0]};
        end else if (is_half) begin
            load_val = {{(DATA_W-16){rword_sh[15] & ~unsigned_m}}, rword_sh[15:0]};
        end else begin
            load_val = rword_sh;
        end
    end

    // Stall covers the accept cycle and every WAIT cycle except the last, so upstream
    // advances exactly on the completion edge.
    assign multi    = (WAIT_CYCLES > 0) & mem_op & (state == S_IDLE);
    assign complete = reset & ~flush_m & valid_m &
                      (((state == S_IDLE) & ~multi) | ((state == S_WAIT) & (cnt == 4'd0)));
    assign stall_m  = reset & ~flush_m & (multi | ((state == S_WAIT) & (cnt != 4'd0)));
    assign mem_we   = complete & mem_write_m & ~bad_addr;

    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_we && be[b]) begin
                mem[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            valid_w      <= 1'b0;
            reg_write_w  <= 1'b0;
            result_src_w <= 1'b0;
            rd_w         <= '0;
            alu_result_w <= '0;
            read_data_w  <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_w   <= 1'b0;
`endif
        end else begin
            valid_w      <= complete;
            reg_write_w  <= complete & reg_write_m & ~bad_addr;
            result_src_w <= complete & result_src_m;
            rd_w         <= complete ? rd_m : 5'd0;
            alu_result_w <= complete ? alu_result_m : '0;
            read_data_w  <= (complete & mem_read_m & ~bad_addr) ? load_val : '0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_w   <= complete & bad_addr;
`endif
            if (flush_m) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (multi) begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                    S_WAIT: begin
                        if (cnt == 4'd0) begin
                            state <= S_IDLE;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign result_w = result_src_w ? read_data_w : alu_result_w;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage (DATA_W=32, DEPTH=256, WAIT_CYCLES=2)
// Build with MEM_ALIGN_CHECK_EN defined to exercise the misalignment trap.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_m, reg_write_m, mem_write_m, mem_read_m, result_src_m;
    logic [4:0]  rd_m;
    logic [1:0]  size_m;
    logic        unsigned_m;
    logic [31:0] alu_result_m, write_data_m;
    logic        flush_m;
    logic        stall_m, valid_w, reg_write_w, result_src_w;
    logic [4:0]  rd_w;
    logic [31:0] alu_result_w, read_data_w, result_w;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_w;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .valid_m      (valid_m),
        .reg_write_m  (reg_write_m),
        .mem_write_m  (mem_write_m),
        .mem_read_m   (mem_read_m),
        .result_src_m (result_src_m),
        .rd_m         (rd_m),
        .size_m       (size_m),
        .unsigned_m   (unsigned_m),
        .alu_result_m (alu_result_m),
        .write_data_m (write_data_m),
        .flush_m      (flush_m),
        .stall_m      (stall_m),
        .valid_w      (valid_w),
        .reg_write_w  (reg_write_w),
        .result_src_w (result_src_w),
        .rd_w         (rd_w),
        .alu_result_w (alu_result_w),
        .read_data_w  (read_data_w),
`ifdef MEM_ALIGN_CHECK_EN
        .misalign_w   (misalign_w),
`endif
        .result_w     (result_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        valid_m = 0; reg_write_m = 0; mem_write_m = 0; mem_read_m = 0; result_src_m = 0;
        rd_m = 0; size_m = 0; unsigned_m = 0; alu_result_m = 0; write_data_m = 0; flush_m = 0;
    endtask

    task automatic drive_mem(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] data);
        valid_m = 1; mem_write_m = wr; mem_read_m = !wr; reg_write_m = !wr; result_src_m = !wr;
        rd_m = wr ? 5'd0 : 5'd9; size_m = sz; unsigned_m = uns; alu_result_m = addr; write_data_m = data;
    endtask

    // Returns just after the completion edge; expects two stall cycles.
    task automatic wait_complete(input string tag);
        int   stalls = 0;
        logic done   = 0;
        logic st;
        for (int i = 0; i < 20 && !done; i++) begin
            #1;
            st = stall_m;
            if (st) stalls++;
            @(posedge clk);
            if (!st) done = 1;
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " stalls"}, 32'(stalls), 32'd2);
    endtask

    task automatic run_op(input string tag, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] data, input logic [31:0] exp_rd);
        @(negedge clk);
        drive_mem(wr, sz, uns, addr, data);
        wait_complete(tag);
        #1;
        check({tag, " valid_w"}, 32'(valid_w), 32'd1);
        check({tag, " reg_write_w"}, 32'(reg_write_w), 32'(!wr));
        check({tag, " rd_w"}, 32'(rd_w), wr ? 32'd0 : 32'd9);
        check({tag, " read_data_w"}, read_data_w, exp_rd);
        check({tag, " result_w"}, result_w, wr ? addr : exp_rd);
        idle();
    endtask

    initial begin
        idle();
        reset = 0;
        drive_mem(1, 2'b10, 0, 32'h10, 32'h12345678);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst stall_m", 32'(stall_m), 0);
        check("rst valid_w", 32'(valid_w), 0);
        check("rst rd_w", 32'(rd_w), 0);
        check("rst result_w", result_w, 0);
        idle();
        reset = 1;

        // plain ALU op: single-cycle, no stall, bubble afterwards
        @(negedge clk);
        valid_m = 1; reg_write_m = 1; alu_result_m = 32'h1234; rd_m = 5'd7;
        #1 check("alu stall_m", 32'(stall_m), 0);
        @(posedge clk); #1;
        check("alu valid_w", 32'(valid_w), 1);
        check("alu reg_write_w", 32'(reg_write_w), 1);
        check("alu rd_w", 32'(rd_w), 7);
        check("alu result_w", result_w, 32'h1234);
        check("alu read_data_w", read_data_w, 0);
        idle();
        @(posedge clk); #1;
        check("alu bubble valid_w", 32'(valid_w), 0);
        check("alu bubble result_w", result_w, 0);

        run_op("st dead", 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0);
        run_op("ld dead", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF);

        run_op("st zero", 1, 2'b10, 0, 32'h10, 32'h0, 32'h0);
        run_op("st b80", 1, 2'b00, 0, 32'h13, 32'h80, 32'h0);
        run_op("ld b s", 0, 2'b00, 0, 32'h13, 32'h0, 32'hFFFFFF80);
        run_op("ld b u", 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000080);
        run_op("ld w13", 0, 2'b10, 0, 32'h10, 32'h0, 32'h80000000);

        run_op("st w30", 1, 2'b11, 0, 32'h30, 32'h0, 32'h0);
        run_op("st h32", 1, 2'b01, 0, 32'h32, 32'h1234BEEF, 32'h0);
        run_op("ld h s", 0, 2'b01, 0, 32'h32, 32'h0, 32'hFFFFBEEF);
        run_op("ld h u", 0, 2'b01, 1, 32'h32, 32'h0, 32'h0000BEEF);
        run_op("ld w30", 0, 2'b10, 0, 32'h30, 32'h0, 32'hBEEF0000);

        // flush during the WAIT of a byte store must leave memory untouched
        run_op("st w20", 1, 2'b10, 0, 32'h20, 32'h11223344, 32'h0);
        @(negedge clk);
        drive_mem(1, 2'b00, 0, 32'h20, 32'h55);
        #1 check("fl accept stall", 32'(stall_m), 1);
        @(negedge clk);
        check("fl wait stall", 32'(stall_m), 1);
        flush_m = 1;
        #1 check("fl stall drop", 32'(stall_m), 0);
        @(posedge clk); #1;
        idle();
        check("fl bubble valid_w", 32'(valid_w), 0);
        check("fl idle stall", 32'(stall_m), 0);
        run_op("ld w20", 0, 2'b10, 0, 32'h20, 32'h0, 32'h11223344);

`ifdef MEM_ALIGN_CHECK_EN
        @(negedge clk);
        drive_mem(0, 2'b01, 1, 32'h21, 32'h0);
        wait_complete("mis");
        #1;
        check("mis misalign_w", 32'(misalign_w), 1);
        check("mis reg_write_w", 32'(reg_write_w), 0);
        check("mis read_data_w", read_data_w, 0);
        idle();
`else
        run_op("ld h21", 0, 2'b01, 1, 32'h21, 32'h0, 32'h00003344);
`endif

        // upper address bits wrap onto the same word
        run_op("st wrap", 1, 2'b10, 0, 32'h1010, 32'h0BADF00D, 32'h0);
        run_op("ld wrap", 0, 2'b10, 0, 32'h10, 32'h0, 32'h0BADF00D);

        // valid_m low: no stall, no write, no writeback
        @(negedge clk);
        valid_m = 0; mem_write_m = 1; reg_write_m = 1; size_m = 2'b10;
        alu_result_m = 32'h10; write_data_m = 32'hFFFFFFFF;
        #1 check("inv stall", 32'(stall_m), 0);
        @(posedge clk); #1;
        check("inv valid_w", 32'(valid_w), 0);
        check("inv reg_write_w", 32'(reg_write_w), 0);
        idle();

        // reset clears the WB register asynchronously
        @(negedge clk);
        valid_m = 1; reg_write_m = 1; alu_result_m = 32'h5A5A; rd_m = 5'd3;
        @(posedge clk); #1;
        check("ar valid_w", 32'(valid_w), 1);
        idle();
        @(negedge clk);
        reset = 0;
        #1;
        check("ar async valid_w", 32'(valid_w), 0);
        check("ar async result_w", result_w, 0);
        check("ar async rd_w", 32'(rd_w), 0);
        @(negedge clk);
        reset = 1;

        // reset during the WAIT of a store aborts it
        @(negedge clk);
        drive_mem(1, 2'b10, 0, 32'h10, 32'hCAFEF00D);
        @(negedge clk);
        check("rw wait stall", 32'(stall_m), 1);
        reset = 0;
        #1;
        check("rw stall drop", 32'(stall_m), 0);
        check("rw valid_w", 32'(valid_w), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        idle();
        reset = 1;
        run_op("ld after rst", 0, 2'b10, 0, 32'h10, 32'h0, 32'h0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
